axis_pattern_gen: RTL and testbench

//   AXI4-Stream master that sources a deterministic byte-ramp test pattern of LEN beats for the DDR bandwidth test.

---
 rtl/axis_pattern_gen.sv | 125 ++++++++++++
 tb/tb_axis_pattern_gen.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/axis_pattern_gen.sv
// AXI4-Stream byte-ramp source for bandwidth testing. It also produces the checksum
// a downstream signed-sum consumer should reach, plus beat/stall/run probe counters.
module axis_pattern_gen #(
  parameter int B = 64
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic [31:0]  len,
  input  logic [7:0]   seed,
  output logic         m_axis_tvalid,
  output logic [B-1:0] m_axis_tdata,
  input  logic         m_axis_tready,
  output logic         m_axis_tlast,
  output logic         busy,
  output logic         done,
  output logic [31:0]  exp_sum,
  output logic [159:0] probe,
  output logic [1:0]   dbg_state
);

  localparam int NB = B / 8;

  // Handshake: a beat transfers on a posedge where tvalid & tready. Once tvalid rises
  // it stays high, and tdata/tlast stay fixed, until that transfer. tvalid ignores tready.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] remaining;
  logic [7:0]  base;
  logic [31:0] beats, stalls, run_cycles;
  logic        hs;

  assign hs        = m_axis_tvalid & m_axis_tready;
  assign probe     = {64'd0, run_cycles, stalls, beats};
  assign dbg_state = state;

  function automatic logic [B-1:0] ramp(input logic [7:0] b0);
    logic [B-1:0] r;
    r = '0;
    for (int j = 0; j < NB; j++) r[8*j +: 8] = b0 + 8'(j);
    return r;
  endfunction

  // The per-beat sum wraps at 8 bits before sign extension, matching the consumer's adder tree.
  function automatic logic [31:0] beat_sum(input logic [B-1:0] d);
    logic [7:0] s;
    s = 8'd0;
    for (int j = 0; j < NB; j++) s = s + d[8*j +: 8];
    return {{24{s[7]}}, s};
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = (len == 32'd0) ? S_DONE : S_RUN;
      S_RUN:  if (hs && m_axis_tlast) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= S_IDLE;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      exp_sum       <= 32'd0;
      remaining     <= 32'd0;
      base          <= 8'd0;
      beats         <= 32'd0;
      stalls        <= 32'd0;
      run_cycles    <= 32'd0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == S_RUN);
      done  <= (state_nxt == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            exp_sum    <= 32'd0;
            beats      <= 32'd0;
            stalls     <= 32'd0;
            run_cycles <= 32'd0;
            if (len != 32'd0) begin
              m_axis_tvalid <= 1'b1;
              m_axis_tdata  <= ramp(seed);
              m_axis_tlast  <= (len == 32'd1);
              remaining     <= len - 32'd1;
              base          <= seed + 8'(NB);
            end
          end
        end
        S_RUN: begin
          run_cycles <= run_cycles + 32'd1;
          if (m_axis_tvalid && !m_axis_tready) stalls <= stalls + 32'd1;
          if (hs) begin
            exp_sum <= exp_sum + beat_sum(m_axis_tdata);
            beats   <= beats + 32'd1;
            if (m_axis_tlast) begin
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
            end else begin
              // remaining counts beats still to follow the one just accepted
              m_axis_tdata <= ramp(base);
              base         <= base + 8'(NB);
              remaining    <= remaining - 32'd1;
              m_axis_tlast <= (remaining == 32'd1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Directed bench for axis_pattern_gen: a table of transfers with hand-computed
// checksums and probe counts, plus hand-written reset-abort and reset-state sequences.
module tb_axis_pattern_gen;

  logic         clk = 1'b0;
  logic         rstn;
  logic         start;
  logic [31:0]  len;
  logic [7:0]   seed;
  logic         tvalid;
  logic [63:0]  tdata;
  logic         tready;
  logic         tlast;
  logic         busy;
  logic         done;
  logic [31:0]  exp_sum;
  logic [159:0] probe;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  axis_pattern_gen #(.B(64)) dut (
    .clk(clk), .rstn(rstn), .start(start), .len(len), .seed(seed),
    .m_axis_tvalid(tvalid), .m_axis_tdata(tdata), .m_axis_tready(tready),
    .m_axis_tlast(tlast), .busy(busy), .done(done), .exp_sum(exp_sum),
    .probe(probe), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  seed;
    logic [31:0] len;
    int          stall_beat;
    int          stall_n;
    bit          poke;
    logic [63:0] exp_d0;
    logic [31:0] exp_sum;
    logic [31:0] exp_beats;
    logic [31:0] exp_stalls;
    logic [31:0] exp_run;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ramp_model(input logic [7:0] b0);
    logic [63:0] r;
    for (int j = 0; j < 8; j++) r[8*j +: 8] = b0 + 8'(j);
    return r;
  endfunction

  // driver: one transfer, checking every presented beat against the scoreboard queue
  task automatic run_vec(input vec_t v);
    int k, stalled, budget;
    exp_q.delete();
    for (int b = 0; b < int'(v.len); b++) exp_q.push_back(ramp_model(v.seed + 8'(8 * b)));
    @(negedge clk);
    start = 1'b1; len = v.len; seed = v.seed; tready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // a start pulse during RUN must not disturb the transfer
    if (v.poke) begin start = 1'b1; len = 32'd5; seed = 8'h99; end
    k = 0; stalled = 0; budget = 0;
    while (k < int'(v.len) && budget < 200) begin
      budget++;
      chk("tvalid", {63'd0, tvalid}, 64'd1);
      chk("busy", {63'd0, busy}, 64'd1);
      chk("state_run", {62'd0, dbg_state}, 64'd1);
      chk("tdata", tdata, exp_q[0]);
      if (k == 0) chk("beat0", tdata, v.exp_d0);
      chk("tlast", {63'd0, tlast}, {63'd0, (k == int'(v.len) - 1)});
      if (k == v.stall_beat && stalled < v.stall_n) begin
        tready = 1'b0;
        stalled++;
      end else begin
        tready = 1'b1;
        if (tvalid) begin
          void'(exp_q.pop_front());
          k++;
        end
      end
      @(negedge clk);
      start = 1'b0;
    end
    if (budget >= 200) chk("beat_budget", 64'(k), 64'(v.len));
    chk("done_pulse", {63'd0, done}, 64'd1);
    chk("tvalid_done", {63'd0, tvalid}, 64'd0);
    chk("busy_done", {63'd0, busy}, 64'd0);
    if (v.poke) begin start = 1'b1; len = 32'd5; seed = 8'h99; end
    @(negedge clk);
    start = 1'b0;
    chk("done_low", {63'd0, done}, 64'd0);
    chk("tvalid_idle", {63'd0, tvalid}, 64'd0);
    chk("state_idle", {62'd0, dbg_state}, 64'd0);
    chk("exp_sum", {32'd0, exp_sum}, {32'd0, v.exp_sum});
    chk("probe_beats", {32'd0, probe[31:0]}, {32'd0, v.exp_beats});
    chk("probe_stalls", {32'd0, probe[63:32]}, {32'd0, v.exp_stalls});
    chk("probe_run", {32'd0, probe[95:64]}, {32'd0, v.exp_run});
    chk("probe_hi", probe[159:96], 64'd0);
  endtask

  initial begin
    //            seed   len  stb stn poke first beat             sum            beats stalls run
    vecs[0] = '{8'h00, 32'd1, -1, 0, 1'b0, 64'h0706050403020100, 32'd28,       32'd1, 32'd0, 32'd1};
    vecs[1] = '{8'h00, 32'd2, -1, 0, 1'b0, 64'h0706050403020100, 32'd120,      32'd2, 32'd0, 32'd2};
    vecs[2] = '{8'h7C, 32'd1, -1, 0, 1'b0, 64'h838281807F7E7D7C, 32'hFFFFFFFC, 32'd1, 32'd0, 32'd1};
    vecs[3] = '{8'h00, 32'd4,  1, 3, 1'b0, 64'h0706050403020100, 32'hFFFFFFF0, 32'd4, 32'd3, 32'd7};
    vecs[4] = '{8'h10, 32'd3, -1, 0, 1'b1, 64'h1716151413121110, 32'hFFFFFF94, 32'd3, 32'd0, 32'd3};
    vecs[5] = '{8'hFC, 32'd3,  0, 2, 1'b0, 64'h03020100FFFEFDFC, 32'h000000B4, 32'd3, 32'd2, 32'd5};
    vecs[6] = '{8'h55, 32'd0, -1, 0, 1'b0, 64'd0,                32'd0,        32'd0, 32'd0, 32'd0};

    rstn = 1'b0; start = 1'b0; len = 32'd0; seed = 8'd0; tready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tvalid", {63'd0, tvalid}, 64'd0);
    chk("rst_tlast", {63'd0, tlast}, 64'd0);
    chk("rst_tdata", tdata, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_exp_sum", {32'd0, exp_sum}, 64'd0);
    chk("rst_probe", probe[63:0], 64'd0);
    chk("rst_state", {62'd0, dbg_state}, 64'd0);
    rstn = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // reset during beat 2 of an 8-beat transfer abandons it with no done
    @(negedge clk);
    start = 1'b1; len = 32'd8; seed = 8'h00; tready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_beat2", tdata, 64'h1716151413121110);
    rstn = 1'b0;
    @(negedge clk);
    chk("abort_tvalid", {63'd0, tvalid}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_exp_sum", {32'd0, exp_sum}, 64'd0);
    chk("abort_probe", probe[95:0], 96'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_done", {63'd0, done}, 64'd0);
      chk("abort_idle", {63'd0, tvalid}, 64'd0);
    end
    run_vec(vecs[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
